qam_symbol_slicer: RTL

Parametrised symbol-decision and serialisation stage of the demodulator receive path; sits after the I and Q matched filters and replaces the fixed QPSK decision/combine pair. Integrates SPS filtered samples per symbol on each channel (integrate-and-dump), slices the sums per a run-time modulation mode (BPSK, QPSK, 16-QAM), then emits the decided bits as a serial stream with valid/ready handshake. Runs on one clock with a sample-valid strobe; no second symbol clock.

---
 rtl/qam_symbol_slicer_if.sv | 24 ++
 rtl/qam_symbol_slicer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/qam_symbol_slicer_if.sv
// Sample-in / serial-bit-out bundle for the QAM symbol slicer.
interface qam_symbol_slicer_if #(
  parameter int DATA_W = 19
);
  logic [1:0]               mode;
  logic                     sync;
  logic                     in_valid;
  logic signed [DATA_W-1:0] I_in;
  logic signed [DATA_W-1:0] Q_in;
  logic                     bit_out;
  logic                     bit_valid;
  logic                     bit_ready;
  logic                     overrun;

  modport master (
    output mode, sync, in_valid, I_in, Q_in, bit_ready,
    input  bit_out, bit_valid, overrun
  );

  modport slave (
    input  mode, sync, in_valid, I_in, Q_in, bit_ready,
    output bit_out, bit_valid, overrun
  );
endinterface

// File: rtl/qam_symbol_slicer.sv
// Integrate-and-dump BPSK/QPSK/16-QAM slicer with serial bit output; first bit one cycle after final sample.
// Bits hold while bit_ready is low; a symbol finishing while the serialiser is busy is dropped and flagged in overrun.
module qam_symbol_slicer #(
  parameter int DATA_W = 19,
  parameter int SPS    = 8,
  parameter int THRESH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  qam_symbol_slicer_if.slave bus
);
  localparam int              CNT_W = $clog2(SPS);
  localparam int              ACC_W = DATA_W + CNT_W;
  localparam logic [ACC_W:0]  T_LIM = (ACC_W + 1)'(THRESH * SPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic [ACC_W:0]          abs_i, abs_q;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              sym_mode;
  logic [3:0]              shreg, sym_bits;
  logic [2:0]              rem, sym_len;
  logic                    vld, ovr;
  logic                    msb_i, msb_q, lsb_i, lsb_q;
  logic                    xfer, sym_done, load;

  // Running sums including the current sample; only consumed on the final sample.
  assign sum_i = acc_i + {{CNT_W{bus.I_in[DATA_W-1]}}, bus.I_in};
  assign sum_q = acc_q + {{CNT_W{bus.Q_in[DATA_W-1]}}, bus.Q_in};

  assign abs_i = sum_i[ACC_W-1] ? -{1'b1, sum_i} : {1'b0, sum_i};
  assign abs_q = sum_q[ACC_W-1] ? -{1'b1, sum_q} : {1'b0, sum_q};

  assign msb_i = ~sum_i[ACC_W-1];
  assign msb_q = ~sum_q[ACC_W-1];
  assign lsb_i = abs_i < T_LIM;
  assign lsb_q = abs_q < T_LIM;

  always_comb begin
    sym_bits = {msb_i, msb_q, 2'b00};
    sym_len  = 3'd2;
    case (sym_mode)
      2'd0: begin
        sym_bits = {msb_i, 3'b000};
        sym_len  = 3'd1;
      end
      2'd2: begin
        sym_bits = {msb_i, lsb_i, msb_q, lsb_q};
        sym_len  = 3'd4;
      end
      default: ;
    endcase
  end

  assign xfer     = vld & bus.bit_ready;
  assign sym_done = bus.in_valid & ~bus.sync & (cnt == LAST);
  // Accept a new symbol when idle or when the last pending bit leaves this cycle.
  assign load     = sym_done & ((rem == 3'd0) | (xfer & (rem == 3'd1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i    <= '0;
      acc_q    <= '0;
      cnt      <= '0;
      sym_mode <= 2'd1;
    end else if (bus.sync) begin
      if (bus.in_valid) begin
        acc_i    <= {{CNT_W{bus.I_in[DATA_W-1]}}, bus.I_in};
        acc_q    <= {{CNT_W{bus.Q_in[DATA_W-1]}}, bus.Q_in};
        cnt      <= CNT_W'(1);
        sym_mode <= bus.mode;
      end else begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end
    end else if (bus.in_valid) begin
      if (cnt == LAST) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + CNT_W'(1);
        if (cnt == '0) sym_mode <= bus.mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      rem   <= '0;
      vld   <= 1'b0;
    end else if (load) begin
      shreg <= sym_bits;
      rem   <= sym_len;
      vld   <= 1'b1;
    end else if (xfer) begin
      shreg <= {shreg[2:0], 1'b0};
      rem   <= rem - 3'd1;
      vld   <= (rem != 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (bus.sync) begin
      ovr <= 1'b0;
    end else if (sym_done & ~load) begin
      ovr <= 1'b1;
    end
  end

  assign bus.bit_out   = shreg[3];
  assign bus.bit_valid = vld;
  assign bus.overrun   = ovr;
endmodule
